timer_apb_ctrl: RTL and testbench

//  APB-slave control/status block for the system timer. Holds the timer configuration
//  and drives the prescaler (timer_en, div_en, div_val). Counts a 64-bit counter on the

---
 rtl/timer_apb_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_timer_apb_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_ctrl.sv
// timer_apb_ctrl: APB slave holding the system-timer configuration.
// It drives the prescaler controls, runs the 64-bit counter on cnt_en pulses,
// compares the counter against TCMP to raise a sticky interrupt status, and
// freezes the counter while the CPU holds the timer in debug halt.
module timer_apb_ctrl #(
  parameter int WAIT_STATES = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tim_psel,
  input  logic        tim_penable,
  input  logic        tim_pwrite,
  input  logic [11:0] tim_paddr,
  input  logic [31:0] tim_pwdata,
  input  logic [3:0]  tim_pstrb,
  output logic [31:0] tim_prdata,
  output logic        tim_pready,
  output logic        tim_pslverr,
  input  logic        dbg_mode,
  input  logic        cnt_en,
  output logic        timer_en,
  output logic        div_en,
  output logic [3:0]  div_val,
  output logic        tim_int
);

  localparam logic [1:0] WS = WAIT_STATES[1:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_t;

  apb_state_t  state, state_nxt;
  logic [1:0]  wait_cnt, wait_cnt_nxt;
  logic        pready_c;

  logic        tcr_en;
  logic        tcr_div_en;
  logic [3:0]  tcr_div_val;
  logic [63:0] counter;
  logic [63:0] cmp;
  logic        int_en;
  logic        int_st;
  logic        halt_req;
  logic        halt_ack;
  logic        tim_int_q;

  logic        addr_hit;
  logic [2:0]  reg_idx;
  logic        commit_wr;
  logic        wr_tcr, wr_tdr0, wr_tdr1, wr_tcmp0, wr_tcmp1;
  logic        wr_tier, wr_tisr, wr_thcsr;
  logic        new_en, new_div_en;
  logic [3:0]  new_div_val;
  logic        tcr_err;
  logic        cnt_inc;
  logic        cmp_match;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  // Replace only the strobed bytes of a 32-bit register image.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  assign unused_addr_lsb = ^tim_paddr[1:0];

  // APB state register and wait-state counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // APB next-state: ready is raised in the last ACCESS cycle; losing psel aborts.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pready_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tim_psel && !tim_penable) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (!tim_psel) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt    = ST_ACCESS;
          wait_cnt_nxt = 2'd0;
        end
      end
      ST_ACCESS: begin
        if (!tim_psel) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt == WS) begin
          pready_c  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          wait_cnt_nxt = 2'(wait_cnt + 2'd1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign addr_hit  = (tim_paddr[11:5] == 7'd0);
  assign reg_idx   = tim_paddr[4:2];
  assign commit_wr = pready_c & tim_pwrite & addr_hit;

  assign wr_tcr    = commit_wr & (reg_idx == 3'd0);
  assign wr_tdr0   = commit_wr & (reg_idx == 3'd1);
  assign wr_tdr1   = commit_wr & (reg_idx == 3'd2);
  assign wr_tcmp0  = commit_wr & (reg_idx == 3'd3);
  assign wr_tcmp1  = commit_wr & (reg_idx == 3'd4);
  assign wr_tier   = commit_wr & (reg_idx == 3'd5) & tim_pstrb[0];
  assign wr_tisr   = commit_wr & (reg_idx == 3'd6) & tim_pstrb[0];
  assign wr_thcsr  = commit_wr & (reg_idx == 3'd7) & tim_pstrb[0];

  // Candidate TCR image after a strobed write; rejected as a whole on error.
  assign new_en      = tim_pstrb[0] ? tim_pwdata[0]    : tcr_en;
  assign new_div_en  = tim_pstrb[0] ? tim_pwdata[1]    : tcr_div_en;
  assign new_div_val = tim_pstrb[1] ? tim_pwdata[11:8] : tcr_div_val;
  assign tcr_err     = (new_div_val > 4'd8) ||
                       (tcr_en && ((new_div_en != tcr_div_en) ||
                                   (new_div_val != tcr_div_val)));

  assign cnt_inc   = cnt_en & tcr_en & ~halt_ack;
  assign cmp_match = (counter == cmp);

  // TCR: prescaler configuration, updated only by an error-free write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tcr_en      <= 1'b0;
      tcr_div_en  <= 1'b0;
      tcr_div_val <= 4'h1;
    end else if (wr_tcr && !tcr_err) begin
      tcr_en      <= new_en;
      tcr_div_en  <= new_div_en;
      tcr_div_val <= new_div_val;
    end
  end

  // 64-bit counter: disable clears, a TDR write overrides a same-cycle increment.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      counter <= 64'd0;
    end else if (wr_tcr && !tcr_err && tcr_en && !new_en) begin
      counter <= 64'd0;
    end else if (wr_tdr0) begin
      counter[31:0] <= merge_bytes(counter[31:0], tim_pwdata, tim_pstrb);
    end else if (wr_tdr1) begin
      counter[63:32] <= merge_bytes(counter[63:32], tim_pwdata, tim_pstrb);
    end else if (cnt_inc) begin
      counter <= counter + 64'd1;
    end
  end

  // Compare value registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr_tcmp0) begin
      cmp[31:0] <= merge_bytes(cmp[31:0], tim_pwdata, tim_pstrb);
    end else if (wr_tcmp1) begin
      cmp[63:32] <= merge_bytes(cmp[63:32], tim_pwdata, tim_pstrb);
    end
  end

  // Interrupt enable and halt request control bits.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      int_en   <= 1'b0;
      halt_req <= 1'b0;
    end else begin
      if (wr_tier)  int_en   <= tim_pwdata[0];
      if (wr_thcsr) halt_req <= tim_pwdata[0];
    end
  end

  // Sticky interrupt status: a new match wins over a coincident clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      int_st <= 1'b0;
    end else if (cmp_match) begin
      int_st <= 1'b1;
    end else if (wr_tisr && tim_pwdata[0]) begin
      int_st <= 1'b0;
    end
  end

  // Registered halt acknowledge and interrupt output.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      halt_ack  <= 1'b0;
      tim_int_q <= 1'b0;
    end else begin
      halt_ack  <= halt_req & dbg_mode;
      tim_int_q <= int_st & int_en;
    end
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rdata = 32'd0;
    if (addr_hit) begin
      case (reg_idx)
        3'd0: rdata = {20'd0, tcr_div_val, 6'd0, tcr_div_en, tcr_en};
        3'd1: rdata = counter[31:0];
        3'd2: rdata = counter[63:32];
        3'd3: rdata = cmp[31:0];
        3'd4: rdata = cmp[63:32];
        3'd5: rdata = {31'd0, int_en};
        3'd6: rdata = {31'd0, int_st};
        3'd7: rdata = {30'd0, halt_ack, halt_req};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign tim_pready  = pready_c;
  assign tim_prdata  = (pready_c && !tim_pwrite) ? rdata : 32'd0;
  assign tim_pslverr = wr_tcr & tcr_err;

  assign timer_en = tcr_en & ~halt_ack;
  assign div_en   = tcr_div_en;
  assign div_val  = tcr_div_val;
  assign tim_int  = tim_int_q;

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Directed testbench for timer_apb_ctrl with hand-computed expectations.
module tb_timer_apb_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        tim_psel = 1'b0;
  logic        tim_penable = 1'b0;
  logic        tim_pwrite = 1'b0;
  logic [11:0] tim_paddr = 12'd0;
  logic [31:0] tim_pwdata = 32'd0;
  logic [3:0]  tim_pstrb = 4'd0;
  logic [31:0] tim_prdata;
  logic        tim_pready;
  logic        tim_pslverr;
  logic        dbg_mode = 1'b0;
  logic        cnt_en = 1'b0;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        tim_int;

  int n_vec = 0;
  int n_err = 0;
  int last_wait = 0;

  timer_apb_ctrl #(.WAIT_STATES(1)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tim_psel    (tim_psel),
    .tim_penable (tim_penable),
    .tim_pwrite  (tim_pwrite),
    .tim_paddr   (tim_paddr),
    .tim_pwdata  (tim_pwdata),
    .tim_pstrb   (tim_pstrb),
    .tim_prdata  (tim_prdata),
    .tim_pready  (tim_pready),
    .tim_pslverr (tim_pslverr),
    .dbg_mode    (dbg_mode),
    .cnt_en      (cnt_en),
    .timer_en    (timer_en),
    .div_en      (div_en),
    .div_val     (div_val),
    .tim_int     (tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic err);
    int n;
    tim_psel = 1'b1; tim_penable = 1'b0; tim_pwrite = wr;
    tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
    @(posedge sys_clk); #1;
    tim_penable = 1'b1;
    n = 0;
    while (!tim_pready && n < 16) begin
      @(posedge sys_clk); #1;
      n++;
    end
    last_wait = n;
    if (!tim_pready) begin
      n_vec++; n_err++;
      $display("FAIL apb_timeout addr=%h pready=%b required=1", a, tim_pready);
    end
    rd  = tim_prdata;
    err = tim_pslverr;
    @(posedge sys_clk); #1;
    tim_psel = 1'b0; tim_penable = 1'b0; tim_pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    logic [31:0] rd;
    apb_xfer(1'b1, a, d, 4'hF, rd, err);
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] rd);
    logic err;
    apb_xfer(1'b0, a, 32'd0, 4'h0, rd, err);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(posedge sys_clk);
    #1;
    n_vec++; if (tim_pready !== 1'b0) begin n_err++; $display("FAIL rst_pready got=%b exp=0", tim_pready); end
    n_vec++; if (tim_pslverr !== 1'b0) begin n_err++; $display("FAIL rst_pslverr got=%b exp=0", tim_pslverr); end
    n_vec++; if (tim_prdata !== 32'd0) begin n_err++; $display("FAIL rst_prdata got=%h exp=0", tim_prdata); end
    n_vec++; if ({timer_en, div_en, tim_int} !== 3'b000) begin n_err++; $display("FAIL rst_ctrl got=%b exp=000", {timer_en, div_en, tim_int}); end
    n_vec++; if (div_val !== 4'h1) begin n_err++; $display("FAIL rst_div_val got=%h exp=1", div_val); end
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    apb_read(12'h000, rd);
    n_vec++; if (rd !== 32'h0000_0100) begin n_err++; $display("FAIL rst_tcr got=%h exp=00000100", rd); end
    apb_read(12'h004, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL rst_tdr0 got=%h exp=0", rd); end
    apb_read(12'h00C, rd);
    n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_tcmp0 got=%h exp=ffffffff", rd); end
    apb_read(12'h010, rd);
    n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_tcmp1 got=%h exp=ffffffff", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic err;
    apb_write(12'h020, 32'hFFFF_FFFF, err);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL unmapped_wr_err got=%b exp=0", err); end
    apb_read(12'h020, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL unmapped_rd got=%h exp=0", rd); end
    apb_read(12'h000, rd);
    n_vec++; if (rd !== 32'h0000_0100) begin n_err++; $display("FAIL unmapped_tcr got=%h exp=00000100", rd); end
  endtask

  task automatic test_count();
    logic [31:0] rd;
    logic err;
    apb_write(12'h000, 32'h0000_0103, err);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL tcr_wr_err got=%b exp=0", err); end
    n_vec++; if (last_wait !== 2) begin n_err++; $display("FAIL access_wait got=%0d exp=2", last_wait); end
    n_vec++; if ({timer_en, div_en, div_val} !== 6'b11_0001) begin n_err++; $display("FAIL tcr_outputs got=%b exp=110001", {timer_en, div_en, div_val}); end
    cnt_en = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1; cnt_en = 1'b0;
    apb_read(12'h004, rd);
    n_vec++; if (rd !== 32'd10) begin n_err++; $display("FAIL count10 got=%0d exp=10", rd); end
  endtask

  task automatic test_tcr_errors();
    logic [31:0] rd;
    logic err;
    apb_write(12'h000, 32'h0000_0303, err);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL div_change_err got=%b exp=1", err); end
    n_vec++; if (div_val !== 4'h1) begin n_err++; $display("FAIL div_change_val got=%h exp=1", div_val); end
    apb_write(12'h000, 32'h0000_0900, err);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL div9_err got=%b exp=1", err); end
    apb_read(12'h000, rd);
    n_vec++; if (rd !== 32'h0000_0103) begin n_err++; $display("FAIL tcr_kept got=%h exp=00000103", rd); end
    apb_write(12'h000, 32'h0000_0102, err);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL disable_err got=%b exp=0", err); end
    apb_read(12'h004, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL disable_clear got=%h exp=0", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic err;
    apb_write(12'h004, 32'hFFFF_FFFE, err);
    apb_write(12'h008, 32'hFFFF_FFFF, err);
    apb_write(12'h000, 32'h0000_0103, err);
    cnt_en = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1; cnt_en = 1'b0;
    apb_read(12'h004, rd);
    n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL wrap_tdr0 got=%h exp=1", rd); end
    apb_read(12'h008, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL wrap_tdr1 got=%h exp=0", rd); end
  endtask

  task automatic test_interrupt();
    logic [31:0] rd;
    logic err;
    apb_write(12'h000, 32'h0000_0102, err);
    apb_write(12'h00C, 32'h0000_0020, err);
    apb_write(12'h010, 32'h0000_0000, err);
    apb_write(12'h018, 32'h0000_0001, err);
    apb_read(12'h018, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL tisr_cleared got=%h exp=0", rd); end
    apb_write(12'h014, 32'h0000_0001, err);
    apb_write(12'h000, 32'h0000_0103, err);
    cnt_en = 1'b1;
    repeat (32) @(posedge sys_clk);
    #1; cnt_en = 1'b0;
    n_vec++; if (tim_int !== 1'b0) begin n_err++; $display("FAIL int_at_match got=%b exp=0", tim_int); end
    @(posedge sys_clk); #1;
    n_vec++; if (tim_int !== 1'b0) begin n_err++; $display("FAIL int_st_cycle got=%b exp=0", tim_int); end
    @(posedge sys_clk); #1;
    n_vec++; if (tim_int !== 1'b1) begin n_err++; $display("FAIL int_asserted got=%b exp=1", tim_int); end
    apb_read(12'h004, rd);
    n_vec++; if (rd !== 32'h20) begin n_err++; $display("FAIL int_count got=%h exp=20", rd); end
    apb_write(12'h018, 32'h0000_0001, err);
    apb_read(12'h018, rd);
    n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL w1c_vs_match got=%h exp=1", rd); end
    apb_write(12'h00C, 32'h0000_0100, err);
    apb_write(12'h018, 32'h0000_0001, err);
    apb_read(12'h018, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL w1c_clear got=%h exp=0", rd); end
    n_vec++; if (tim_int !== 1'b0) begin n_err++; $display("FAIL int_dropped got=%b exp=0", tim_int); end
  endtask

  task automatic test_halt();
    logic [31:0] rd;
    logic err;
    apb_write(12'h01C, 32'h0000_0001, err);
    dbg_mode = 1'b1;
    @(posedge sys_clk); #1;
    n_vec++; if (timer_en !== 1'b0) begin n_err++; $display("FAIL halt_timer_en got=%b exp=0", timer_en); end
    apb_read(12'h01C, rd);
    n_vec++; if (rd !== 32'd3) begin n_err++; $display("FAIL halt_thcsr got=%h exp=3", rd); end
    cnt_en = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
    apb_read(12'h004, rd);
    cnt_en = 1'b0;
    n_vec++; if (rd !== 32'h20) begin n_err++; $display("FAIL halt_frozen got=%h exp=20", rd); end
    dbg_mode = 1'b0;
    @(posedge sys_clk); #1;
    n_vec++; if (timer_en !== 1'b1) begin n_err++; $display("FAIL release_timer_en got=%b exp=1", timer_en); end
    cnt_en = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1; cnt_en = 1'b0;
    apb_read(12'h004, rd);
    n_vec++; if (rd !== 32'h25) begin n_err++; $display("FAIL resume_count got=%h exp=25", rd); end
  endtask

  task automatic test_tdr_vs_inc();
    logic [31:0] rd;
    logic err;
    apb_write(12'h004, 32'hFFFF_FFF0, err);
    cnt_en = 1'b1;
    apb_write(12'h008, 32'h0000_0007, err);
    cnt_en = 1'b0;
    apb_read(12'h004, rd);
    n_vec++; if (rd !== 32'hFFFF_FFF3) begin n_err++; $display("FAIL tdr_inc_lo got=%h exp=fffffff3", rd); end
    apb_read(12'h008, rd);
    n_vec++; if (rd !== 32'h7) begin n_err++; $display("FAIL tdr_inc_hi got=%h exp=7", rd); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd;
    logic err;
    apb_write(12'h010, 32'h0000_0007, err);
    apb_write(12'h00C, 32'hFFFF_FFF3, err);
    repeat (2) @(posedge sys_clk);
    #1;
    n_vec++; if (tim_int !== 1'b1) begin n_err++; $display("FAIL pre_reset_int got=%b exp=1", tim_int); end
    tim_psel = 1'b1; tim_penable = 1'b0; tim_pwrite = 1'b1;
    tim_paddr = 12'h000; tim_pwdata = 32'd0; tim_pstrb = 4'hF;
    @(posedge sys_clk); #1;
    tim_penable = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    #1;
    n_vec++; if (tim_pready !== 1'b0) begin n_err++; $display("FAIL midrst_pready got=%b exp=0", tim_pready); end
    n_vec++; if ({timer_en, div_en, tim_int} !== 3'b000) begin n_err++; $display("FAIL midrst_ctrl got=%b exp=000", {timer_en, div_en, tim_int}); end
    n_vec++; if (div_val !== 4'h1) begin n_err++; $display("FAIL midrst_div_val got=%h exp=1", div_val); end
    tim_psel = 1'b0; tim_penable = 1'b0; tim_pwrite = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    apb_read(12'h000, rd);
    n_vec++; if (rd !== 32'h0000_0100) begin n_err++; $display("FAIL midrst_tcr got=%h exp=00000100", rd); end
    apb_read(12'h008, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL midrst_tdr1 got=%h exp=0", rd); end
    apb_read(12'h00C, rd);
    n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL midrst_tcmp0 got=%h exp=ffffffff", rd); end
  endtask

  initial begin
    test_reset();
    test_unmapped();
    test_count();
    test_tcr_errors();
    test_wrap();
    test_interrupt();
    test_halt();
    test_tdr_vs_inc();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
